// File: rtl/blockade_wav_player_if.sv
// Sample-player bus: boom trigger in, sample ROM read port, and the mixer-side sample outputs.
interface blockade_wav_player_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  trigger;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [7:0]            rom_data;
  logic [15:0]           sample_out;
  logic                  sample_strobe;
  logic                  playing;
  logic                  done;

  modport master (
    output trigger,
    output rom_data,
    input  rom_addr,
    input  sample_out,
    input  sample_strobe,
    input  playing,
    input  done
  );

  modport slave (
    input  trigger,
    input  rom_data,
    output rom_addr,
    output sample_out,
    output sample_strobe,
    output playing,
    output done
  );
endinterface

// File: rtl/blockade_wav_player.sv
// Plays the recorded "boom" sample from an external registered ROM at a fixed rate on a trigger edge.
// Optional BLOCKADE_WAV_RETRIGGER_EN: a trigger edge during playback restarts from address 0.
module blockade_wav_player #(
  parameter int ADDR_WIDTH    = 16,
  parameter int SAMPLE_LENGTH = 38174,
  parameter int RATE_DIV      = 1000,
  parameter int GAIN_SHIFT    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  blockade_wav_player_if.slave   bus
);
  localparam int CW = $clog2(RATE_DIV);
  localparam logic [ADDR_WIDTH-1:0] LEN      = ADDR_WIDTH'(SAMPLE_LENGTH);
  localparam logic [CW-1:0]         CNT_LOAD = CW'(RATE_DIV - 3);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, WAIT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  trig_q;
  logic [15:0]           sample_q, sample_d;
  logic                  strobe_q, strobe_d;
  logic                  playing_q, playing_d;
  logic                  done_q, done_d;

  logic                  trig_edge;
  logic                  restart;
  logic signed [15:0]    byte_ext;
  logic signed [15:0]    sample_ext;

  assign trig_edge  = bus.trigger & ~trig_q;
  assign byte_ext   = {{8{bus.rom_data[7]}}, bus.rom_data};
  assign sample_ext = byte_ext <<< GAIN_SHIFT;

`ifdef BLOCKADE_WAV_RETRIGGER_EN
  assign restart = trig_edge;
`else
  assign restart = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    sample_d  = sample_q;
    strobe_d  = 1'b0;
    playing_d = playing_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_edge) begin
          addr_d    = '0;
          playing_d = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        // End of sample wins over a coincident edge, so a new rising edge is needed afterwards.
        if (addr_q == LEN) begin
          state_d   = IDLE;
          sample_d  = '0;
          playing_d = 1'b0;
          done_d    = 1'b1;
        end else if (restart) begin
          addr_d  = '0;
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        sample_d = sample_ext;
        strobe_d = 1'b1;
        if (restart) begin
          addr_d  = '0;
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (restart) begin
          addr_d  = '0;
          cnt_d   = '0;
          state_d = FETCH;
        end else if (cnt_q == '0) begin
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      trig_q    <= 1'b0;
      sample_q  <= '0;
      strobe_q  <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      trig_q    <= bus.trigger;
      sample_q  <= sample_d;
      strobe_q  <= strobe_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign bus.rom_addr      = addr_q;
  assign bus.sample_out    = sample_q;
  assign bus.sample_strobe = strobe_q;
  assign bus.playing       = playing_q;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_blockade_wav_player.sv
// Bench for blockade_wav_player: three parameterisations share one trigger/reset and one ROM image,
// each compared every cycle against a timeline model of the playback.
module tb_blockade_wav_player;
  localparam int AW = 8;
  localparam int NI = 3;
  localparam int P_LEN [NI] = '{3, 5, 0};
  localparam int P_R   [NI] = '{4, 3, 4};
  localparam int P_G   [NI] = '{8, 0, 4};
`ifdef BLOCKADE_WAV_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic trigger;
  logic [7:0] rom [256];
  int checks = 0;
  int failures = 0;
  bit trg;

  bit          m_trig;
  bit          m_busy [NI];
  int          m_r    [NI];
  logic [15:0] m_held [NI];
  logic [15:0] m_out  [NI];
  logic [AW-1:0] m_addr [NI];
  bit          m_play [NI];
  bit          m_strb [NI];
  bit          m_done [NI];

  always #5 clk = ~clk;

  blockade_wav_player_if #(.ADDR_WIDTH(AW)) bus_a ();
  blockade_wav_player_if #(.ADDR_WIDTH(AW)) bus_b ();
  blockade_wav_player_if #(.ADDR_WIDTH(AW)) bus_c ();

  assign bus_a.trigger = trigger;
  assign bus_b.trigger = trigger;
  assign bus_c.trigger = trigger;

  // Registered sample ROM, one per instance
  always @(posedge clk) begin
    bus_a.rom_data <= rom[bus_a.rom_addr];
    bus_b.rom_data <= rom[bus_b.rom_addr];
    bus_c.rom_data <= rom[bus_c.rom_addr];
  end

  blockade_wav_player #(.ADDR_WIDTH(AW), .SAMPLE_LENGTH(P_LEN[0]), .RATE_DIV(P_R[0]), .GAIN_SHIFT(P_G[0]))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  blockade_wav_player #(.ADDR_WIDTH(AW), .SAMPLE_LENGTH(P_LEN[1]), .RATE_DIV(P_R[1]), .GAIN_SHIFT(P_G[1]))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
  blockade_wav_player #(.ADDR_WIDTH(AW), .SAMPLE_LENGTH(P_LEN[2]), .RATE_DIV(P_R[2]), .GAIN_SHIFT(P_G[2]))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c.slave));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ext(logic [7:0] b, int g);
    int v;
    v = int'($signed(b)) * (1 << g);
    return v[15:0];
  endfunction

  // Playback as a timeline: r counts cycles since entering FETCH; sample k is strobed at r=2+k*R,
  // playback ends with done at r=LEN*R+1.
  task automatic model_step(int i, bit rst, bit tedge);
    int rp;
    int len;
    int rr;
    bit lstrobe;
    len = P_LEN[i];
    rr = P_R[i];
    lstrobe = 1'b0;
    m_done[i] = 1'b0;
    m_strb[i] = 1'b0;
    if (rst) begin
      m_busy[i] = 1'b0;
      m_out[i]  = '0;
      m_play[i] = 1'b0;
      m_addr[i] = '0;
      return;
    end
    if (m_busy[i]) begin
      rp = m_r[i];
      if (rp == len * rr) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b1;
        m_out[i]  = '0;
        m_play[i] = 1'b0;
      end else if (RETRIG && tedge) begin
        if (rp % rr == 1) begin
          m_held[i] = ext(rom[(rp - 1) / rr], P_G[i]);
          lstrobe = 1'b1;
        end else begin
          m_held[i] = m_out[i];
        end
        m_r[i] = 0;
      end else begin
        m_r[i] = rp + 1;
      end
    end else if (tedge) begin
      m_busy[i] = 1'b1;
      m_r[i]    = 0;
      m_held[i] = '0;
    end
    if (m_busy[i]) begin
      rp = m_r[i];
      m_play[i] = 1'b1;
      m_strb[i] = (rp >= 2 && (rp - 2) % rr == 0) || (rp == 0 && lstrobe);
      m_out[i]  = (rp < 2) ? m_held[i] : ext(rom[(rp - 2) / rr], P_G[i]);
      m_addr[i] = AW'((rp + rr - 2) / rr);
    end
  endtask

  task automatic check_inst(int i, logic [15:0] so, logic st, logic pl, logic dn, logic [AW-1:0] ra);
    chk($sformatf("sample_out[%0d]", i), 32'(so), 32'(m_out[i]));
    chk($sformatf("strobe[%0d]", i),     32'(st), 32'(m_strb[i]));
    chk($sformatf("playing[%0d]", i),    32'(pl), 32'(m_play[i]));
    chk($sformatf("done[%0d]", i),       32'(dn), 32'(m_done[i]));
    chk($sformatf("rom_addr[%0d]", i),   32'(ra), 32'(m_addr[i]));
  endtask

  task automatic cyc(bit rst, bit t);
    bit te;
    @(negedge clk);
    reset = rst;
    trigger = t;
    @(posedge clk);
    te = t && !m_trig;
    for (int i = 0; i < NI; i++) model_step(i, rst, te);
    m_trig = rst ? 1'b0 : t;
    #1;
    check_inst(0, bus_a.sample_out, bus_a.sample_strobe, bus_a.playing, bus_a.done, bus_a.rom_addr);
    check_inst(1, bus_b.sample_out, bus_b.sample_strobe, bus_b.playing, bus_b.done, bus_b.rom_addr);
    check_inst(2, bus_c.sample_out, bus_c.sample_strobe, bus_c.playing, bus_c.done, bus_c.rom_addr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h10;
    rom[1] = 8'hF0;
    rom[2] = 8'h7F;
    rom[3] = 8'h80;
    reset = 1'b1;
    trigger = 1'b0;
    m_trig = 1'b0;
    trg = 1'b0;

    repeat (3) cyc(1'b1, 1'b0);

    // Single pulse: full playback on every instance
    cyc(1'b0, 1'b1);
    repeat (30) cyc(1'b0, 1'b0);

    // Held trigger fires once
    repeat (50) cyc(1'b0, 1'b1);
    repeat (20) cyc(1'b0, 1'b0);

    // Reset during the wait after sample 1, then replay
    cyc(1'b0, 1'b1);
    repeat (7) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    repeat (30) cyc(1'b0, 1'b0);

    // Second rising edge during sample 1
    cyc(1'b0, 1'b1);
    repeat (6) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    repeat (40) cyc(1'b0, 1'b0);

    // Trigger immediately after reset counts as an edge
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    repeat (30) cyc(1'b0, 1'b0);

    repeat (4000) begin
      if ($urandom_range(7) == 0) trg = !trg;
      cyc($urandom_range(299) == 0, trg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
